// File: rtl/muldiv_unit_if.sv
// ============================================================================
//  muldiv_unit_if
//  Request/response bundle between the core and the RV32M multiply/divide
//  unit: start/funct3/operands in, busy/done/result/err out.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic            err;

    // Core side: issues requests and consumes results
    modport master (
        output start, funct3, rs1_data, rs2_data,
        input  busy, done, result, err
    );

    // Unit side: accepts requests and produces results
    modport slave (
        input  start, funct3, rs1_data, rs2_data,
        output busy, done, result, err
    );
endinterface

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
//  muldiv_unit
//  Iterative RV32M multiply/divide unit. Radix-2 shift-add multiplier and
//  restoring divider sharing one 64-bit working register, 32 iterations,
//  followed by one sign-fixup cycle.
//  Build option: MULDIV_DIV_EN enables the divide datapath; without it any
//  funct3[2]=1 op completes immediately with result=0, err=1.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  wire logic      clk,
    input  wire logic      rst,
    muldiv_unit_if.slave   bus
);

    localparam int              DW   = 2 * XLEN;
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q;
    logic [2:0]      op_q;
    logic            neg_res_q;
    logic [5:0]      cnt_q;
    logic [DW-1:0]   acc_q;
    logic [XLEN-1:0] opnd_q;
    logic            busy_q;
    logic            done_q;
    logic            err_q;
    logic [XLEN-1:0] result_q;

    logic            a_signed_d;
    logic            b_signed_d;
    logic            neg_a_d;
    logic            neg_b_d;
    logic [XLEN-1:0] abs_a_d;
    logic [XLEN-1:0] abs_b_d;
    logic            fast_d;
    logic [XLEN-1:0] fast_res_d;
    logic            fast_err_d;

    logic [XLEN:0]   mul_sum_d;
    logic [DW-1:0]   mul_step_d;
    logic [DW-1:0]   step_d;
    logic [DW-1:0]   prod_d;
    logic [XLEN-1:0] mul_res_d;
    logic [XLEN-1:0] fix_res_d;

`ifdef MULDIV_DIV_EN
    logic            neg_rem_q;
    logic            dbz_d;
    logic            ovf_d;
    logic [XLEN:0]   div_shift_d;
    logic [XLEN:0]   div_diff_d;
    logic            div_qbit_d;
    logic [XLEN-1:0] div_rem_d;
    logic [DW-1:0]   div_step_d;
    logic [XLEN-1:0] quo_d;
    logic [XLEN-1:0] rem_d;
`endif

    // Decode the incoming request: operand signs, magnitudes and fast-path ops
    always_comb begin
        a_signed_d = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                     (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
        b_signed_d = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                     (bus.funct3 == 3'b110);
        neg_a_d    = a_signed_d && bus.rs1_data[XLEN-1];
        neg_b_d    = b_signed_d && bus.rs2_data[XLEN-1];
        abs_a_d    = neg_a_d ? -bus.rs1_data : bus.rs1_data;
        abs_b_d    = neg_b_d ? -bus.rs2_data : bus.rs2_data;
`ifdef MULDIV_DIV_EN
        dbz_d      = bus.funct3[2] && (bus.rs2_data == '0);
        // Only signed DIV/REM (funct3[0]=0) can overflow
        ovf_d      = bus.funct3[2] && !bus.funct3[0] &&
                     (bus.rs1_data == SMIN) && (bus.rs2_data == '1);
        fast_d     = dbz_d || ovf_d;
        fast_err_d = 1'b0;
        if (dbz_d) begin
            fast_res_d = bus.funct3[1] ? bus.rs1_data : '1;
        end else begin
            fast_res_d = bus.funct3[1] ? '0 : SMIN;
        end
`else
        fast_d     = bus.funct3[2];
        fast_res_d = '0;
        fast_err_d = 1'b1;
`endif
    end

    // One iteration of the multiplier (and divider, when present)
    always_comb begin
        mul_sum_d  = {1'b0, acc_q[DW-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_step_d = {mul_sum_d, acc_q[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
        // High half holds the partial remainder, low half shifts dividend out / quotient in
        div_shift_d = {acc_q[DW-1:XLEN], acc_q[XLEN-1]};
        div_diff_d  = div_shift_d - {1'b0, opnd_q};
        div_qbit_d  = !div_diff_d[XLEN];
        div_rem_d   = div_qbit_d ? div_diff_d[XLEN-1:0] : div_shift_d[XLEN-1:0];
        div_step_d  = {div_rem_d, acc_q[XLEN-2:0], div_qbit_d};
        step_d      = op_q[2] ? div_step_d : mul_step_d;
`else
        step_d      = mul_step_d;
`endif
    end

    // Sign fixup and result selection
    always_comb begin
        prod_d    = neg_res_q ? -acc_q : acc_q;
        mul_res_d = (op_q == 3'b000) ? prod_d[XLEN-1:0] : prod_d[DW-1:XLEN];
`ifdef MULDIV_DIV_EN
        quo_d     = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_d     = neg_rem_q ? -acc_q[DW-1:XLEN] : acc_q[DW-1:XLEN];
        fix_res_d = op_q[2] ? (op_q[1] ? rem_d : quo_d) : mul_res_d;
`else
        fix_res_d = mul_res_d;
`endif
    end

    // Control FSM with registered busy/done/result/err
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            neg_res_q <= 1'b0;
`ifdef MULDIV_DIV_EN
            neg_rem_q <= 1'b0;
`endif
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            result_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        op_q      <= bus.funct3;
                        neg_res_q <= neg_a_d ^ neg_b_d;
`ifdef MULDIV_DIV_EN
                        neg_rem_q <= neg_a_d;
`endif
                        cnt_q     <= '0;
                        // Divide shifts |A| through the register against |B|;
                        // multiply shifts |B| out while adding |A|
                        acc_q     <= {{XLEN{1'b0}}, (bus.funct3[2] ? abs_a_d : abs_b_d)};
                        opnd_q    <= bus.funct3[2] ? abs_b_d : abs_a_d;
                        if (fast_d) begin
                            state_q  <= S_DONE;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            result_q <= fast_res_d;
                            err_q    <= fast_err_d;
                        end else begin
                            state_q  <= S_BUSY;
                            busy_q   <= 1'b1;
                            done_q   <= 1'b0;
                        end
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                S_BUSY: begin
                    acc_q <= step_d;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    state_q  <= S_DONE;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    result_q <= fix_res_d;
                    err_q    <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.err    = err_q;

endmodule

`default_nettype wire
